train_sb_msg_arbiter: RTL and testbench
=======================================

Name: train_sb_msg_arbiter

Overview:
- Sequences and shares the MBTRAIN sideband transmit path between two requesters: the TX-side and RX-side train/center-cal FSMs.
- Accepts one 4-bit encoded message at a time and issues it with a single-cycle valid.
- Holds the grant until the sideband encoder signals completion with a falling edge of busy, then acknowledges the granted requester.
- Uses round-robin priority on collisions and a watchdog timeout; sits between the train-center-cal FSMs and the sideband encoder.

Parameters:
- TIMEOUT_CYCLES, 1023, cycles in WAIT_DONE before the transfer is abandoned.
- CNT_W, 10, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- i_en  input  1  block enable; low forces IDLE
- i_tx_req  input  1  TX-side FSM requests a send; level, held until o_tx_done or o_timeout
- i_tx_msg  input  4  TX-side decoded message code
- i_rx_req  input  1  RX-side FSM requests a send; level
- i_rx_msg  input  4  RX-side decoded message code
- i_busy  input  1  sideband encoder busy; a falling edge means the message was sent
- o_sideband_message  output  4  message to the sideband encoder
- o_valid  output  1  one-cycle issue strobe
- o_tx_done  output  1  one-cycle ack to TX-side requester
- o_rx_done  output  1  one-cycle ack to RX-side requester
- o_timeout  output  1  one-cycle pulse when a transfer is abandoned
- o_grant_rx  output  1  0 = current/last grant TX, 1 = RX

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all outputs 0 (o_sideband_message=4'b0000).
  - busy_q=0; timeout counter=0; last_grant=RX, so TX wins the first collision.
- All outputs are registered.
- Falling-edge detect: busy_fall = busy_q & ~i_busy, where busy_q is i_busy registered every cycle regardless of state.
- State IDLE:
  - Only one request high: grant it.
  - Both high: grant the requester that is not last_grant.
  - On grant, latch the granted message into o_sideband_message, set o_grant_rx, update last_grant, go to ISSUE.
  - No request: stay; o_sideband_message keeps its last value.
- State ISSUE:
  - o_valid=1 for exactly this cycle.
  - Clear the counter; go to WAIT_DONE.
  - Latency from request seen in IDLE to o_valid is 1 cycle.
- State WAIT_DONE:
  - o_valid=0; o_sideband_message stays stable.
  - Counter increments each cycle.
  - busy_fall: go to DONE.
  - Else if counter == TIMEOUT_CYCLES-1: pulse o_timeout next cycle, no done pulse, go to IDLE.
  - If busy_fall and timeout coincide, busy_fall wins (DONE).
  - A busy_fall detected during the ISSUE cycle is ignored; only edges seen in WAIT_DONE count.
- State DONE:
  - Pulse o_tx_done or o_rx_done (per the grant) for 1 cycle, then IDLE.
  - The requester must drop its req the cycle after it sees done.
  - The arbiter samples requests again in the cycle after DONE; a still-high req there is treated as a new request.
- Request deasserted after grant: the transfer still completes and done still pulses.
- Message inputs are sampled only at grant; later changes are ignored until the next grant.
- Back-to-back with both requesters continuously requesting: grants strictly alternate TX, RX, TX, ...
- i_en=0 (synchronous):
  - Next cycle state=IDLE; o_valid, done and timeout pulses are 0; counter cleared.
  - last_grant is kept; o_sideband_message is cleared to 0.
  - An in-flight transfer is dropped with no done pulse.
- Reset mid-transfer: immediate return to reset values; no done pulse.
- Counter never wraps; it saturates at TIMEOUT_CYCLES-1 in WAIT_DONE.

Test Plan:
- Single TX req, msg=4'h5; i_busy rises 2 cycles after o_valid and falls 6 cycles later -> o_sideband_message=5, o_valid exactly 1 cycle (1 cycle after req), o_tx_done 1 cycle after the busy fall, o_grant_rx=0.
- i_tx_req and i_rx_req rise together (msgs 3 and 9), each completing normally -> first grant TX (3), then RX (9); a third collision grants TX again.
- i_busy held 0 after a TX req with TIMEOUT_CYCLES=16 -> o_timeout pulses 16 cycles after WAIT_DONE entry, no o_tx_done, return to IDLE.
- i_en dropped while in WAIT_DONE -> next cycle all outputs 0, no done; a later i_en=1 with RX req issues normally.
- rst_n asserted mid-WAIT_DONE, then released, then simultaneous requests -> outputs 0 during reset; first post-reset grant is TX.
- i_tx_msg changed from 4'h2 to 4'hA during WAIT_DONE -> o_sideband_message stays 2 until done.

Source files
------------

// File: rtl/train_sb_msg_arbiter.sv
// Arbitrates the MBTRAIN sideband transmit path between the TX-side and RX-side
// train/center-cal FSMs: one message in flight, round-robin on collisions, watchdog timeout.
module train_sb_msg_arbiter #(
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int CNT_W          = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_en,
    input  logic       i_tx_req,
    input  logic [3:0] i_tx_msg,
    input  logic       i_rx_req,
    input  logic [3:0] i_rx_msg,
    input  logic       i_busy,
    output logic [3:0] o_sideband_message,
    output logic       o_valid,
    output logic       o_tx_done,
    output logic       o_rx_done,
    output logic       o_timeout,
    output logic       o_grant_rx
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_DONE,
        ST_DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_reg;
    logic             busy_q_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             last_grant_rx_reg;
    logic [3:0]       msg_reg;
    logic             valid_reg;
    logic             tx_done_reg;
    logic             rx_done_reg;
    logic             timeout_reg;
    logic             grant_rx_reg;

    logic busy_fall;
    logic pick_rx;

    assign busy_fall = busy_q_reg & ~i_busy;

    // On a collision the side that did not win last time gets the path.
    always_comb begin
        pick_rx = i_rx_req;
        if (i_tx_req && i_rx_req) begin
            pick_rx = ~last_grant_rx_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= ST_IDLE;
            busy_q_reg        <= 1'b0;
            cnt_reg           <= '0;
            last_grant_rx_reg <= 1'b1;
            msg_reg           <= 4'b0000;
            valid_reg         <= 1'b0;
            tx_done_reg       <= 1'b0;
            rx_done_reg       <= 1'b0;
            timeout_reg       <= 1'b0;
            grant_rx_reg      <= 1'b0;
        end else begin
            busy_q_reg  <= i_busy;
            valid_reg   <= 1'b0;
            tx_done_reg <= 1'b0;
            rx_done_reg <= 1'b0;
            timeout_reg <= 1'b0;
            if (!i_en) begin
                state_reg    <= ST_IDLE;
                cnt_reg      <= '0;
                msg_reg      <= 4'b0000;
                grant_rx_reg <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (i_tx_req || i_rx_req) begin
                            msg_reg           <= pick_rx ? i_rx_msg : i_tx_msg;
                            grant_rx_reg      <= pick_rx;
                            last_grant_rx_reg <= pick_rx;
                            valid_reg         <= 1'b1;
                            state_reg         <= ST_ISSUE;
                        end
                    end
                    ST_ISSUE: begin
                        cnt_reg   <= '0;
                        state_reg <= ST_WAIT_DONE;
                    end
                    ST_WAIT_DONE: begin
                        // A completion edge beats a timeout landing on the same cycle.
                        if (busy_fall) begin
                            tx_done_reg <= ~grant_rx_reg;
                            rx_done_reg <= grant_rx_reg;
                            state_reg   <= ST_DONE;
                        end else if (cnt_reg == CNT_LAST) begin
                            timeout_reg <= 1'b1;
                            state_reg   <= ST_IDLE;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                    ST_DONE: begin
                        state_reg <= ST_IDLE;
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_sideband_message = msg_reg;
    assign o_valid            = valid_reg;
    assign o_tx_done          = tx_done_reg;
    assign o_rx_done          = rx_done_reg;
    assign o_timeout          = timeout_reg;
    assign o_grant_rx         = grant_rx_reg;

endmodule

// File: tb/tb_train_sb_msg_arbiter.sv
// Randomised bench for train_sb_msg_arbiter: a transaction-level model queues the expected
// issue/done/timeout events and an independent monitor compares them as the DUT emits them.
module tb_train_sb_msg_arbiter;

    localparam int TMO     = 16;
    localparam int K_ISSUE = 0;
    localparam int K_TXD   = 1;
    localparam int K_RXD   = 2;
    localparam int K_TMO   = 3;

    typedef struct packed {
        logic [1:0] kind;
        logic [3:0] msg;
        logic       grant_rx;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   m_last_rx = 1'b1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_en = 1'b0;
    logic       i_tx_req = 1'b0;
    logic [3:0] i_tx_msg = 4'h0;
    logic       i_rx_req = 1'b0;
    logic [3:0] i_rx_msg = 4'h0;
    logic       i_busy = 1'b0;
    logic [3:0] o_sideband_message;
    logic       o_valid;
    logic       o_tx_done;
    logic       o_rx_done;
    logic       o_timeout;
    logic       o_grant_rx;

    train_sb_msg_arbiter #(
        .TIMEOUT_CYCLES(TMO),
        .CNT_W         (5)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_en              (i_en),
        .i_tx_req          (i_tx_req),
        .i_tx_msg          (i_tx_msg),
        .i_rx_req          (i_rx_req),
        .i_rx_msg          (i_rx_msg),
        .i_busy            (i_busy),
        .o_sideband_message(o_sideband_message),
        .o_valid           (o_valid),
        .o_tx_done         (o_tx_done),
        .o_rx_done         (o_rx_done),
        .o_timeout         (o_timeout),
        .o_grant_rx        (o_grant_rx)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string name);
        check(name, int'({o_sideband_message, o_valid, o_tx_done, o_rx_done, o_timeout, o_grant_rx}), 0);
    endtask

    // Monitor: every output event must match the head of the scoreboard.
    task automatic sb_pop(input int kind, input string nm);
        exp_t e;
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_%s: event seen with empty scoreboard, got 1 event required 0 (t=%0t)", nm, $time);
        end else begin
            e = sb_q.pop_front();
            check({"sb_kind_", nm}, kind, int'(e.kind));
            check({"sb_msg_", nm}, int'(o_sideband_message), int'(e.msg));
            check({"sb_grant_", nm}, int'(o_grant_rx), int'(e.grant_rx));
            $display("event %s msg=%0h grant_rx=%0d", nm, o_sideband_message, o_grant_rx);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (o_valid)   sb_pop(K_ISSUE, "issue");
            if (o_tx_done) sb_pop(K_TXD, "tx_done");
            if (o_rx_done) sb_pop(K_RXD, "rx_done");
            if (o_timeout) sb_pop(K_TMO, "timeout");
        end
    end

    // Model: one granted transfer yields an issue event followed by done or timeout.
    task automatic push_xfer(input bit g_rx, input logic [3:0] msg, input int bmode, input bit ends);
        exp_t e;
        e.kind = 2'(K_ISSUE);
        e.msg = msg;
        e.grant_rx = g_rx;
        sb_q.push_back(e);
        if (ends) begin
            e.kind = (bmode == 1) ? 2'(K_TMO) : (g_rx ? 2'(K_RXD) : 2'(K_TXD));
            sb_q.push_back(e);
        end
        m_last_rx = g_rx;
    endtask

    task automatic drop(input bit g_rx);
        if (g_rx) i_rx_req = 1'b0;
        else      i_tx_req = 1'b0;
    endtask

    task automatic set_msg(input bit g_rx, input int m);
        if (g_rx) i_rx_msg = 4'(m);
        else      i_tx_msg = 4'(m);
    endtask

    // Acts as granted requester and sideband encoder; entered at the negedge showing o_valid.
    task automatic serve(input int bmode, input int d1, input int d2, input int chg_msg, input bit early_drop);
        bit g_rx;
        int n;
        int dn;
        g_rx = o_grant_rx;
        if (early_drop) drop(g_rx);
        if (bmode == 1) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
                if (n == 3 && chg_msg >= 0) set_msg(g_rx, chg_msg);
            end while (!o_timeout && !o_tx_done && !o_rx_done && n < TMO + 8);
            check("timeout_latency", n, TMO + 1);
            check("timeout_pulse", int'(o_timeout), 1);
        end else begin
            if (bmode == 2) begin
                d1 = 0;
                d2 = TMO;
            end
            repeat (d1) @(negedge clk);
            i_busy = 1'b1;
            if (chg_msg >= 0) set_msg(g_rx, chg_msg);
            repeat (d2) @(negedge clk);
            i_busy = 1'b0;
            @(negedge clk);
            dn = g_rx ? int'(o_rx_done) : int'(o_tx_done);
            if (g_rx) check("rx_done_latency", dn, 1);
            else      check("tx_done_latency", dn, 1);
        end
        drop(g_rx);
    endtask

    task automatic do_round(input bit rq_t, input bit rq_r, input logic [3:0] mt, input logic [3:0] mr,
                            input int bmode, input int d1, input int d2, input int chg_msg, input bit early_drop);
        bit first_rx;
        int n;
        first_rx = (rq_t && rq_r) ? !m_last_rx : rq_r;
        push_xfer(first_rx, first_rx ? mr : mt, bmode, 1'b1);
        if (rq_t && rq_r) push_xfer(!first_rx, first_rx ? mt : mr, bmode, 1'b1);
        $display("round tx_req=%0d rx_req=%0d tx_msg=%0h rx_msg=%0h busy_mode=%0d", rq_t, rq_r, mt, mr, bmode);
        @(negedge clk);
        i_tx_msg = mt;
        i_rx_msg = mr;
        i_tx_req = rq_t;
        i_rx_req = rq_r;
        @(negedge clk);
        check("issue_latency", int'(o_valid), 1);
        serve(bmode, d1, d2, chg_msg, early_drop);
        if (rq_t && rq_r) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!o_valid && n < 8);
            check("regrant_gap", n, (bmode == 1) ? 1 : 2);
            serve(bmode, d1, d2, chg_msg, early_drop);
        end
        i_tx_req = 1'b0;
        i_rx_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int  sel;
        int  bsel;
        int  bmode;
        int  chg;
        bit  rq_t;
        bit  rq_r;

        repeat (2) @(negedge clk);
        check_all_zero("reset_outputs");
        rst_n = 1'b1;
        i_en = 1'b1;
        @(negedge clk);
        check_all_zero("idle_outputs");

        // Directed cases
        do_round(1'b1, 1'b0, 4'h5, 4'h0, 0, 2, 6, -1, 1'b0);
        do_round(1'b1, 1'b1, 4'h3, 4'h9, 0, 1, 3, -1, 1'b0);
        do_round(1'b1, 1'b1, 4'h6, 4'hE, 0, 0, 2, -1, 1'b0);
        do_round(1'b1, 1'b0, 4'h8, 4'h0, 1, 0, 0, -1, 1'b0);
        do_round(1'b1, 1'b0, 4'h2, 4'h0, 0, 1, 5, 'hA, 1'b0);
        do_round(1'b1, 1'b0, 4'hB, 4'h0, 2, 0, 0, -1, 1'b0);
        do_round(1'b0, 1'b1, 4'h0, 4'h7, 0, 3, 4, -1, 1'b1);

        // Enable dropped mid-transfer: no done, outputs cleared, grant history kept
        push_xfer(1'b0, 4'h7, 0, 1'b0);
        @(negedge clk);
        i_tx_msg = 4'h7;
        i_tx_req = 1'b1;
        @(negedge clk);
        check("en_issue_latency", int'(o_valid), 1);
        @(negedge clk);
        i_busy = 1'b1;
        repeat (3) @(negedge clk);
        i_en = 1'b0;
        i_tx_req = 1'b0;
        @(negedge clk);
        check_all_zero("en_low_outputs");
        i_busy = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("en_low_hold");
        i_en = 1'b1;
        do_round(1'b0, 1'b1, 4'h0, 4'hC, 0, 1, 2, -1, 1'b0);

        // Reset mid-WAIT_DONE after a TX grant: the next collision must still go to TX
        push_xfer(1'b0, 4'h6, 0, 1'b0);
        @(negedge clk);
        i_tx_msg = 4'h6;
        i_tx_req = 1'b1;
        @(negedge clk);
        check("rst_issue_latency", int'(o_valid), 1);
        i_busy = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset_outputs");
        i_tx_req = 1'b0;
        i_busy = 1'b0;
        m_last_rx = 1'b1;
        @(negedge clk);
        check_all_zero("reset_hold_outputs");
        rst_n = 1'b1;
        do_round(1'b1, 1'b1, 4'h1, 4'hD, 0, 2, 2, -1, 1'b0);

        // Randomised rounds
        for (int r = 0; r < 40; r++) begin
            sel  = $urandom_range(0, 2);
            rq_t = (sel != 1);
            rq_r = (sel != 0);
            bsel = $urandom_range(0, 9);
            bmode = (bsel < 7) ? 0 : ((bsel < 9) ? 1 : 2);
            chg = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 15)) : -1;
            do_round(rq_t, rq_r, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), bmode,
                     int'($urandom_range(0, 3)), int'($urandom_range(1, 6)), chg,
                     bit'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        check("sb_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
